// File: rtl/axil_reg_pkg.sv
// Shared types for the AXI4-Lite register responder: channel FSM states and
// the response code.
package axil_reg_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave exposing a small bank of word registers; write and read
// channels run independent FSMs, every access answers OKAY.
module axil_reg_responder
    import axil_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    input  logic [ADDR_WIDTH-1:0]                S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_out,
    output logic [NUM_REGS-1:0]                  wr_pulse
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic [IDX_W-1:0]                   awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0]              wdata_q, wdata_d;
    logic [STRB_W-1:0]                  wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0]                wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0]              rdata_q;

    logic aw_hs, w_hs, ar_hs, do_write;
    logic unused_ok;

    // Byte lane and protection bits carry no meaning for word registers.
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies are gated by reset so they read 0 while it is held and 1 on the
    // very first cycle after release.
    assign S_AXI_AWREADY = !ARESET && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_D);
    assign S_AXI_WREADY  = !ARESET && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_A);
    assign S_AXI_ARREADY = !ARESET && (rd_state_q == R_IDLE);

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign S_AXI_BVALID = (wr_state_q == W_RESP);
    assign S_AXI_BRESP  = RESP_OKAY;
    assign S_AXI_RVALID = (rd_state_q == R_RESP);
    assign S_AXI_RRESP  = RESP_OKAY;
    assign S_AXI_RDATA  = rdata_q;
    assign reg_out      = regs_q;
    assign wr_pulse     = wr_pulse_q;

    // The _d values are the live beat when it arrives this cycle, else the held one.
    always_comb begin
        awidx_d    = aw_hs ? S_AXI_AWADDR[ADDR_WIDTH-1:2] : awidx_q;
        wdata_d    = w_hs ? S_AXI_WDATA : wdata_q;
        wstrb_d    = w_hs ? S_AXI_WSTRB : wstrb_q;
        wr_state_d = wr_state_q;
        do_write   = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    do_write   = 1'b1;
                    wr_state_d = W_RESP;
                end else if (aw_hs) begin
                    wr_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    wr_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    do_write   = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    do_write   = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        wr_pulse_d = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            wr_pulse_d[r] = do_write && (awidx_d == IDX_W'(r));
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_RESP;
            R_RESP:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_pulse_q <= wr_pulse_d;
            // Read samples the old register value, so a same-edge write is not seen.
            if (ar_hs) rdata_q <= regs_q[S_AXI_ARADDR[ADDR_WIDTH-1:2]];
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (wr_pulse_d[r]) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (wstrb_d[b]) regs_q[r][8*b +: 8] <= wdata_d[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder; expected B/R responses are queued by
// the stimulus and checked by an independent monitor.
module tb_axil_reg_responder;
    import axil_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0][31:0] reg_out;
    logic [3:0]  wr_pulse;

    int vectors = 0;
    int errors  = 0;
    logic [1:0]  b_q[$];
    logic [31:0] r_q[$];
    int pulse_cnt[4];

    always #5 clk = ~clk;

    axil_reg_responder dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Scoreboard monitor: every completed B/R handshake must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (b_q.size() == 0) fail_now("unexpected_bvalid");
                else check("bresp", bresp, b_q.pop_front());
            end
            if (rvalid && rready) begin
                if (r_q.size() == 0) fail_now("unexpected_rvalid");
                else begin
                    check("rdata", rdata, r_q.pop_front());
                    check("rresp", rresp, RESP_OKAY);
                end
            end
            for (int i = 0; i < 4; i++) if (wr_pulse[i]) pulse_cnt[i]++;
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) fail_now(name);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0, w_done = 0, aw_acc, w_acc;
        int n = 0;
        b_q.push_back(RESP_OKAY);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_acc) begin aw_done = 1; awvalid = 0; end
            if (w_acc) begin w_done = 1; wvalid = 0; end
            n++;
        end
        awvalid = 0; wvalid = 0;
        if (n >= 50) fail_now("write_accept");
        wait_drain("write_resp");
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
        bit acc = 0;
        int n = 0;
        r_q.push_back(exp);
        araddr = a; arvalid = 1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 0;
        if (n >= 50) fail_now("read_accept");
        wait_drain("read_resp");
    endtask

    initial begin
        rst = 1; awaddr = 0; araddr = 0; awprot = 3'b010; arprot = 3'b101;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        wdata = 0; wstrb = 0;
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_readies", {awready, wready, arready}, 3'b000);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_regs", reg_out, 128'h0);
        check("rst_pulse", wr_pulse, 4'h0);
        check("rst_rdata", rdata, 32'h0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("post_rst_readies", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;

        // Basic write/readback across all registers, addr[1:0] junk ignored
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h5, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hF, 32'h4, 4'hF);
        check("reg_out_all", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});
        for (int i = 0; i < 4; i++) check("pulse_once", pulse_cnt[i], 1);
        axi_read(4'h0, 32'h1);
        axi_read(4'h4, 32'h2);
        axi_read(4'hA, 32'h3);
        axi_read(4'hC, 32'h4);

        // Byte strobes
        axi_write(4'h0, 32'hAABBCCDD, 4'hF);
        axi_write(4'h0, 32'h11223344, 4'b0101);
        axi_read(4'h0, 32'hAA22CC44);

        // W leads AW by three cycles
        b_q.push_back(RESP_OKAY);
        wdata = 32'hCAFE0002; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        check("w_first_wready", wready, 1'b1);
        @(posedge clk); #1 wvalid = 0;
        repeat (3) begin
            @(negedge clk);
            check("w_held_wready", wready, 1'b0);
            check("w_held_awready", awready, 1'b1);
            check("w_held_reg2", reg_out[2], 32'h3);
            check("w_held_bvalid", bvalid, 1'b0);
            @(posedge clk); #1;
        end
        awaddr = 4'h8; awvalid = 1;
        @(posedge clk); #1 awvalid = 0;
        @(negedge clk);
        check("aw_late_reg2", reg_out[2], 32'hCAFE0002);
        check("aw_late_pulse", wr_pulse, 4'b0100);
        check("aw_late_bvalid", bvalid, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_bvalid", bvalid, 1'b0);
        check("pulse_one_cycle", wr_pulse, 4'b0000);
        @(posedge clk); #1;
        wait_drain("w_lead_resp");

        // Back-pressure on B
        bready = 0;
        b_q.push_back(RESP_OKAY);
        awaddr = 4'h4; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1 awvalid = 0; wvalid = 0;
        repeat (5) begin
            @(negedge clk);
            check("bstall_bvalid", bvalid, 1'b1);
            check("bstall_readies", {awready, wready}, 2'b00);
            @(posedge clk); #1;
        end
        bready = 1;
        wait_drain("bstall_resp");
        axi_write(4'h4, 32'h88, 4'hF);
        axi_read(4'h4, 32'h88);

        // Same-edge read and write of one register returns the old value
        axi_write(4'h4, 32'h5, 4'hF);
        b_q.push_back(RESP_OKAY);
        r_q.push_back(32'h5);
        awaddr = 4'h4; wdata = 32'h9; wstrb = 4'hF; araddr = 4'h4;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(negedge clk);
        check("same_edge_readies", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1 awvalid = 0; wvalid = 0; arvalid = 0;
        wait_drain("same_edge_resp");
        axi_read(4'h4, 32'h9);

        // Reset between AW and W discards the captured address
        awaddr = 4'hC; awvalid = 1;
        @(posedge clk); #1 awvalid = 0;
        #2 rst = 1;
        #1;
        check("mid_rst_readies", {awready, wready, arready}, 3'b000);
        check("mid_rst_valids", {bvalid, rvalid}, 2'b00);
        check("mid_rst_regs", reg_out, 128'h0);
        check("mid_rst_pulse", wr_pulse, 4'h0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("mid_rst_post_readies", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); #1 wvalid = 0;
        repeat (2) begin
            @(negedge clk);
            check("stale_aw_bvalid", bvalid, 1'b0);
            check("stale_aw_reg3", reg_out[3], 32'h0);
            @(posedge clk); #1;
        end
        b_q.push_back(RESP_OKAY);
        awaddr = 4'hC; awvalid = 1;
        @(posedge clk); #1 awvalid = 0;
        wait_drain("post_rst_resp");
        axi_read(4'hC, 32'h5A5A5A5A);

        repeat (2) @(negedge clk);
        check("b_queue_empty", b_q.size(), 0);
        check("r_queue_empty", r_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/axil_reg_responder.md
AXIL_REG_RESPONDER -- requirements
Module: axil_reg_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning byte address width covering 4 word registers.
REQ-003 SHALL have parameter NUM_REGS, default 4, meaning the register count, fixed at 2**(ADDR_WIDTH-2).
REQ-004 SHALL have port ACLK, input, 1, the single clock.
REQ-005 SHALL have port ARESET, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have ports S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: the write address channel.
REQ-007 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: the write data channel.
REQ-008 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: the write response channel.
REQ-009 SHALL have ports S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: the read address channel.
REQ-010 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: the read data channel.
REQ-011 SHALL have port reg_out, output, NUM_REGS x 32, the current register contents.
REQ-012 SHALL have port wr_pulse, output, NUM_REGS, a one-cycle strobe per register written.

Function
REQ-013 Write FSM SHALL have states W_IDLE, W_HAVE_A, W_HAVE_D and W_RESP.
REQ-014 AWREADY SHALL be high in W_IDLE and W_HAVE_D; WREADY SHALL be high in W_IDLE and W_HAVE_A; both SHALL be low in W_RESP.
REQ-015 AW and W SHALL be accepted in either order or in the same cycle; the captured address/data SHALL be held until the pair is complete.
REQ-016 The register SHALL update, with per-byte WSTRB masking, on the edge completing the AW+W pair, and the FSM SHALL enter W_RESP on that edge.
REQ-017 wr_pulse[index] SHALL be high for exactly the cycle after that update.
REQ-018 In W_RESP, BVALID SHALL be 1 with BRESP=OKAY (2'b00), held until BREADY; the FSM SHALL return to W_IDLE on the BVALID&BREADY edge.
REQ-019 Read FSM SHALL have states R_IDLE and R_RESP; ARREADY SHALL be high only in R_IDLE.
REQ-020 On the AR handshake edge, RDATA SHALL capture reg[ARADDR[ADDR_WIDTH-1:2]], RVALID SHALL rise and RRESP SHALL be OKAY, giving RVALID one cycle after the handshake.
REQ-021 RDATA/RVALID SHALL hold stable until RREADY; return to R_IDLE SHALL occur on the RVALID&RREADY edge.
REQ-022 ADDR[1:0] and AxPROT SHALL be ignored; no address SHALL return SLVERR/DECERR.
REQ-023 A read and a write to the same register completing on the same edge SHALL return the pre-write value.
REQ-024 Read and write FSMs SHALL operate independently and concurrently.

Reset
REQ-025 When ARESET is high, all registers, RDATA, wr_pulse, BVALID and RVALID SHALL be 0, AWREADY/WREADY/ARREADY SHALL be 0, and both FSMs SHALL be in idle, asynchronously.
REQ-026 Assertion mid-transaction SHALL discard any partial capture; the first post-reset cycle SHALL present AWREADY=WREADY=ARREADY=1.

Structure
REQ-027 A package axil_reg_pkg SHALL hold the write/read state enums and RESP_OKAY; no sub-modules.

Verification
REQ-028 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read each back -> RDATA 0x1..0x4, all BRESP/RRESP=OKAY, wr_pulse bits 0..3 each pulse once.
REQ-029 Reg0=0xAABBCCDD, write 0x11223344 with WSTRB=4'b0101 -> readback 0xAA22CC44.
REQ-030 WVALID 3 cycles before AWVALID to 0x8 -> WREADY drops after W accept, reg2 updates only after AW, single BVALID.
REQ-031 BREADY held low 5 cycles -> BVALID stays high, AWREADY/WREADY low throughout, next write accepted after BREADY.
REQ-032 Reg1=0x5; same-edge write 0x9 and read of 0x4 -> RDATA=0x5, subsequent read=0x9.
REQ-033 ARESET pulsed after AW accepted but before W -> no register change, no BVALID, all outputs 0, readies return high.
